mmc1_serial_writer: RTL

MMC1_SERIAL_WRITER -- requirements
Module: mmc1_serial_writer

---
 rtl/mmc1_serial_writer.sv | 119 +++++++++++
 1 files changed

// File: rtl/mmc1_serial_writer.sv
// Serialises a 5-bit MMC1 register load into single-bit CPU bus writes,
// optionally preceded by a shift-register reset write, paced by the CPU tick ce.
module mmc1_serial_writer #(
  parameter int unsigned GAP_CE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_reg,
  input  logic [4:0]  req_data,
  input  logic        req_reset,
  output logic [15:0] prg_ain_o,
  output logic [7:0]  prg_din_o,
  output logic        prg_write_o,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_WR  = 3'd1,
    RST_GAP = 3'd2,
    BIT_WR  = 3'd3,
    BIT_GAP = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP_CE);

  state_t     state, state_d;
  logic [1:0] reg_q;
  logic [4:0] data_q;
  logic [2:0] bit_idx, bit_idx_d;
  logic [3:0] gap_cnt, gap_cnt_d;
  logic       done_d;
  logic       accept;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      reg_q   <= 2'd0;
      data_q  <= 5'd0;
      bit_idx <= 3'd0;
      gap_cnt <= 4'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      bit_idx <= bit_idx_d;
      gap_cnt <= gap_cnt_d;
      done    <= done_d;
      if (accept) begin
        reg_q  <= req_reg;
        data_q <= req_data;
      end
    end
  end

  // Handshake: a request transfers on any clk edge where req_valid & req_ready,
  // whatever ce is; req_ready is high only in IDLE, so the sequence is
  // immune to req_* changes until it finishes.
  always_comb begin
    state_d   = state;
    bit_idx_d = bit_idx;
    gap_cnt_d = gap_cnt;
    done_d    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          bit_idx_d = 3'd0;
          gap_cnt_d = 4'd0;
          state_d   = req_reset ? RST_WR : BIT_WR;
        end
      end
      RST_WR, BIT_WR: begin
        if (ce) begin
          gap_cnt_d = GAP_LD;
          state_d   = (state == RST_WR) ? RST_GAP : BIT_GAP;
        end
      end
      RST_GAP, BIT_GAP: begin
        if (ce) begin
          if (gap_cnt <= 4'd1) begin
            gap_cnt_d = 4'd0;
            if (state == RST_GAP) begin
              state_d = BIT_WR;
            end else if (bit_idx == 3'd4) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d   = BIT_WR;
              bit_idx_d = bit_idx + 3'd1;
            end
          end else begin
            gap_cnt_d = gap_cnt - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == IDLE);
    busy        = (state != IDLE);
    prg_write_o = (state == RST_WR) || (state == BIT_WR);
    prg_ain_o   = (state == IDLE) ? 16'h0000 : {1'b1, reg_q, 13'h0000};
    case (state)
      RST_WR:  prg_din_o = 8'h80;
      BIT_WR:  prg_din_o = {7'b0, data_q[bit_idx]};
      default: prg_din_o = 8'h00;
    endcase
    dbg_state = state;
  end

endmodule
